// File: rtl/showahead_fifo_nx1_var.sv
// Single-clock show-ahead FIFO: pushes rows of up to N lanes with a per-row valid
// length, and presents the valid lanes of the head row one element per rd_req.
module showahead_fifo_nx1_var #(
  parameter int N           = 8,
  parameter int N_L         = $clog2(N),
  parameter int WIDTH       = 1,
  parameter int DEPTH       = 512,
  parameter int D_L         = $clog2(DEPTH),
  parameter int FULL_THRESH = DEPTH - 6
) (
  input  logic                    clk,
  input  logic                    aclr,
  input  logic                    wr_req,
  input  logic [N-1:0][WIDTH-1:0] wr_data,
  input  logic [N_L:0]            wr_len,
  output logic                    wr_full,
  output logic                    wr_full_b,
  output logic [D_L:0]            wr_count,
  output logic                    wr_overflow,
  input  logic                    rd_req,
  input  logic                    rd_all,
  output logic [WIDTH-1:0]        rd_data,
  output logic [N-1:0][WIDTH-1:0] rd_data_all,
  output logic [N_L-1:0]          rd_lane,
  output logic                    rd_last,
  output logic                    rd_empty,
  output logic                    rd_not_empty,
  output logic [D_L:0]            rd_count,
  output logic                    rd_underflow
);

  localparam logic [N_L:0] N_LEN      = (N_L+1)'(N);
  localparam logic [D_L:0] DEPTH_CNT  = (D_L+1)'(DEPTH);
  localparam logic [D_L:0] THRESH_CNT = (D_L+1)'(FULL_THRESH);

  logic [N-1:0][WIDTH-1:0] mem_data [DEPTH];
  logic [N_L:0]            mem_len  [DEPTH];

  logic [D_L-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [N_L-1:0] rd_lane_reg;
  logic [D_L:0]   count_reg, count_next;
  logic           full_reg, overflow_reg, underflow_reg;

  logic [N_L:0]            eff_len, head_len;
  logic [N-1:0][WIDTH-1:0] head_row;
  logic                    empty, wr_valid, rd_valid, row_end, pop, accept;

  assign eff_len  = (wr_len > N_LEN) ? N_LEN : wr_len;
  assign empty    = (count_reg == '0);
  assign wr_valid = wr_req & (wr_len != '0);
  assign rd_valid = rd_req & ~empty;
  assign head_len = mem_len[rd_ptr_reg];
  assign head_row = mem_data[rd_ptr_reg];
  assign row_end  = ({1'b0, rd_lane_reg} == head_len - 1'b1);
  assign pop      = rd_valid & (rd_all | row_end);
  // A pop in the same cycle frees the slot, so a write at DEPTH still lands.
  assign accept   = wr_valid & ((count_reg != DEPTH_CNT) | pop);

  assign count_next = count_reg + (D_L+1)'(accept) - (D_L+1)'(pop);

  // Row store is not reset; its contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data[wr_ptr_reg] <= wr_data;
      mem_len[wr_ptr_reg]  <= eff_len;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      rd_lane_reg   <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      full_reg  <= (count_next >= THRESH_CNT);
      if (accept)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (wr_valid & ~accept)
        overflow_reg <= 1'b1;
      if (rd_req & empty)
        underflow_reg <= 1'b1;
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_lane_reg <= '0;
      end else if (rd_valid) begin
        rd_lane_reg <= rd_lane_reg + 1'b1;
      end
    end
  end

  // Lanes beyond the row's length, and everything while empty, read as zero.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane_mask
      assign rd_data_all[gi] = (~empty && (head_len > (N_L+1)'(gi))) ? head_row[gi] : '0;
    end
  endgenerate

  assign rd_data      = rd_data_all[rd_lane_reg];
  assign rd_lane      = rd_lane_reg;
  assign rd_last      = ~empty & row_end;
  assign rd_empty     = empty;
  assign rd_not_empty = ~empty;
  assign wr_full      = full_reg;
  assign wr_full_b    = ~full_reg;
  assign wr_count     = count_reg;
  assign rd_count     = count_reg;
  assign wr_overflow  = overflow_reg;
  assign rd_underflow = underflow_reg;

endmodule

// File: tb/tb_showahead_fifo_nx1_var.sv
// Directed bench for showahead_fifo_nx1_var: row serialization, skip, fill/overflow,
// underflow, a randomized model-checked stream and asynchronous clear.
module tb_showahead_fifo_nx1_var;

  localparam int N     = 8;
  localparam int N_L   = 3;
  localparam int WIDTH = 8;
  localparam int DEPTH = 512;
  localparam int D_L   = 9;

  logic                    clk = 1'b0;
  logic                    aclr;
  logic                    wr_req;
  logic [N-1:0][WIDTH-1:0] wr_data;
  logic [N_L:0]            wr_len;
  logic                    wr_full, wr_full_b, wr_overflow;
  logic [D_L:0]            wr_count, rd_count;
  logic                    rd_req, rd_all;
  logic [WIDTH-1:0]        rd_data;
  logic [N-1:0][WIDTH-1:0] rd_data_all;
  logic [N_L-1:0]          rd_lane;
  logic                    rd_last, rd_empty, rd_not_empty, rd_underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0][WIDTH-1:0] d;
    int                      len;
  } row_t;
  row_t q[$];

  showahead_fifo_nx1_var #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .aclr(aclr),
    .wr_req(wr_req), .wr_data(wr_data), .wr_len(wr_len),
    .wr_full(wr_full), .wr_full_b(wr_full_b), .wr_count(wr_count), .wr_overflow(wr_overflow),
    .rd_req(rd_req), .rd_all(rd_all), .rd_data(rd_data), .rd_data_all(rd_data_all),
    .rd_lane(rd_lane), .rd_last(rd_last), .rd_empty(rd_empty), .rd_not_empty(rd_not_empty),
    .rd_count(rd_count), .rd_underflow(rd_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input logic [7:0] base);
    for (int l = 0; l < N; l++) wr_data[l] = base + 8'(l);
  endtask

  function automatic logic [63:0] masked(input logic [7:0] base, input int len);
    logic [N-1:0][WIDTH-1:0] r;
    r = '0;
    for (int l = 0; l < len; l++) r[l] = base + 8'(l);
    return r;
  endfunction

  initial begin
    aclr = 1'b1; wr_req = 1'b0; wr_data = '0; wr_len = '0; rd_req = 1'b0; rd_all = 1'b0;
    #1;
    chk("rst_empty", rd_empty, 1);
    chk("rst_not_empty", rd_not_empty, 0);
    chk("rst_full", wr_full, 0);
    chk("rst_full_b", wr_full_b, 1);
    chk("rst_last", rd_last, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_data_all", rd_data_all, 0);
    chk("rst_count", wr_count, 0);
    @(negedge clk);
    aclr = 1'b0;

    // Row A, len 3: serialize A0..A2
    wr_req = 1'b1; wr_len = 3; set_row(8'hA0);
    tick();
    wr_req = 1'b0;
    chk("a_data0", rd_data, 8'hA0);
    chk("a_lane0", rd_lane, 0);
    chk("a_last0", rd_last, 0);
    chk("a_count", rd_count, 1);
    chk("a_data_all", rd_data_all, masked(8'hA0, 3));
    rd_req = 1'b1;
    tick();
    chk("a_data1", rd_data, 8'hA1);
    chk("a_last1", rd_last, 0);
    tick();
    chk("a_data2", rd_data, 8'hA2);
    chk("a_lane2", rd_lane, 2);
    chk("a_last2", rd_last, 1);
    tick();
    rd_req = 1'b0;
    chk("a_empty", rd_empty, 1);
    chk("a_count_end", wr_count, 0);
    chk("a_data_empty", rd_data, 0);

    // Rows B (len 8) and C (len 2), skip rest of B with rd_all
    wr_req = 1'b1; wr_len = 8; set_row(8'hB0);
    tick();
    wr_len = 2; set_row(8'hC0);
    tick();
    wr_req = 1'b0;
    chk("bc_count", wr_count, 2);
    rd_req = 1'b1; rd_all = 1'b1;
    tick();
    chk("skip_data", rd_data, 8'hC0);
    chk("skip_lane", rd_lane, 0);
    chk("skip_count", rd_count, 1);
    chk("skip_last", rd_last, 0);
    tick();
    rd_req = 1'b0; rd_all = 1'b0;
    chk("skip_empty", rd_empty, 1);

    // Underflow while empty, sticky; zero-length write ignored
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("uf_flag", rd_underflow, 1);
    chk("uf_count", rd_count, 0);
    tick();
    chk("uf_sticky", rd_underflow, 1);
    wr_req = 1'b1; wr_len = 0; set_row(8'h90);
    tick();
    wr_req = 1'b0;
    chk("len0_count", wr_count, 0);
    chk("len0_empty", rd_empty, 1);
    chk("len0_ovf", wr_overflow, 0);

    // wr_len above N clamps to N
    wr_req = 1'b1; wr_len = 15; set_row(8'hD0);
    tick();
    wr_req = 1'b0;
    chk("clamp_all", rd_data_all, masked(8'hD0, 8));
    rd_req = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("clamp_lane7", rd_data, 8'hD7);
    chk("clamp_last", rd_last, 1);
    tick();
    rd_req = 1'b0;
    chk("clamp_empty", rd_empty, 1);

    // Fill to full threshold and depth
    wr_req = 1'b1; wr_len = 1; wr_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data[0] = i[7:0];
      tick();
      if (i == 504) begin
        chk("fill_505_full", wr_full, 0);
        chk("fill_505_count", wr_count, 505);
      end
      if (i == 505) begin
        chk("fill_506_full", wr_full, 1);
        chk("fill_506_full_b", wr_full_b, 0);
        chk("fill_506_count", wr_count, 506);
      end
    end
    chk("fill_512_count", wr_count, 512);
    chk("fill_512_ovf", wr_overflow, 0);
    wr_data[0] = 8'hEE;
    tick();
    chk("drop_ovf", wr_overflow, 1);
    chk("drop_count", wr_count, 512);
    wr_data[0] = 8'h5A; rd_req = 1'b1;
    tick();
    wr_req = 1'b0;
    chk("wp_count", wr_count, 512);
    chk("wp_head", rd_data, 8'h01);
    for (int i = 1; i < DEPTH; i++) begin
      if (rd_data !== i[7:0]) chk("drain_data", rd_data, i[7:0]);
      tick();
    end
    chk("drain_tail", rd_data, 8'h5A);
    tick();
    rd_req = 1'b0;
    chk("drain_empty", rd_empty, 1);
    chk("drain_full", wr_full, 0);

    // Randomized stream against a queue model
    begin
      int sent = 0;
      int mlane = 0;
      row_t r;
      for (int cyc = 0; cyc < 400 && (sent < 20 || q.size() > 0); cyc++) begin
        wr_req = (sent < 20) && ($urandom_range(0, 1) == 1);
        wr_len = 4'($urandom_range(1, 8));
        for (int l = 0; l < N; l++) wr_data[l] = 8'($urandom);
        rd_req = ($urandom_range(0, 2) != 0);
        rd_all = ($urandom_range(0, 3) == 0);
        if (rd_req && q.size() > 0) begin
          if (rd_all || mlane == q[0].len - 1) begin
            void'(q.pop_front());
            mlane = 0;
          end else begin
            mlane++;
          end
        end
        if (wr_req) begin
          r.d = wr_data; r.len = int'(wr_len);
          q.push_back(r);
          sent++;
        end
        tick();
        chk("rand_count", rd_count, q.size());
        chk("rand_data", rd_data, (q.size() > 0) ? q[0].d[mlane] : 8'h00);
        chk("rand_last", rd_last, (q.size() > 0) && (mlane == q[0].len - 1));
        chk("rand_lane", rd_lane, (q.size() > 0) ? mlane : 0);
      end
      wr_req = 1'b0; rd_req = 1'b0; rd_all = 1'b0;
      chk("rand_done", q.size(), 0);
    end

    // Asynchronous clear mid-stream at count 5, lane 3
    wr_req = 1'b1; wr_len = 8;
    for (int k = 0; k < 5; k++) begin
      set_row(8'h30 + 8'(k * 16));
      tick();
    end
    wr_req = 1'b0; rd_req = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    rd_req = 1'b0;
    chk("pre_clr_count", rd_count, 5);
    chk("pre_clr_lane", rd_lane, 3);
    chk("pre_clr_data", rd_data, 8'h33);
    chk("pre_clr_uf", rd_underflow, 1);
    #3;
    aclr = 1'b1;
    #1;
    chk("clr_empty", rd_empty, 1);
    chk("clr_count", wr_count, 0);
    chk("clr_lane", rd_lane, 0);
    chk("clr_data", rd_data, 0);
    chk("clr_data_all", rd_data_all, 0);
    chk("clr_uf", rd_underflow, 0);
    chk("clr_ovf", wr_overflow, 0);
    #1;
    aclr = 1'b0;
    wr_req = 1'b1; wr_len = 1; wr_data = '0; wr_data[0] = 8'h77;
    tick();
    wr_req = 1'b0;
    chk("post_clr_data", rd_data, 8'h77);
    chk("post_clr_count", rd_count, 1);
    chk("post_clr_last", rd_last, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
